// File: rtl/i2s_stream_loop.sv
// i2s_stream_loop: stereo sample loop between an ADC and a DAC stream.
// Each channel has its own FIFO. L/R pairs are popped together, processed
// (pass/swap/mix/mute plus an arithmetic attenuation shift) and held in a
// one-entry output register per channel. A level detector drives a held LED.
module i2s_stream_loop #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] THRESH   = 32'h1000_0000,
    parameter int unsigned HOLD_CYC = 2_500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [2:0]        shift,
    input  logic [DATA_W-1:0] adc_l_tdata,
    input  logic [DATA_W-1:0] adc_r_tdata,
    input  logic [1:0]        adc_tvalid,
    output logic [1:0]        adc_tready,
    output logic [DATA_W-1:0] dac_l_tdata,
    output logic [DATA_W-1:0] dac_r_tdata,
    output logic [1:0]        dac_tvalid,
    input  logic [1:0]        dac_tready,
    output logic [1:0]        ovf,
    output logic              led_out
);

    localparam int unsigned PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned HW = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);
    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
    localparam logic [HW-1:0]     HOLD_LD  = HW'(HOLD_CYC);
    localparam logic [DATA_W-1:0] THR      = DATA_W'(THRESH);
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] din  [2];
    logic [DATA_W-1:0] head [2];
    logic [1:0]        nonempty;
    logic [1:0]        push;
    logic              load;

    assign din[0] = adc_l_tdata;
    assign din[1] = adc_r_tdata;

    // A pair moves out only when both sides have data and both output slots can take it
    assign load = (&nonempty)
                & (~dac_tvalid[0] | dac_tready[0])
                & (~dac_tvalid[1] | dac_tready[1]);

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PW-1:0]     wr_ptr;
        logic [PW-1:0]     rd_ptr;
        logic [CW-1:0]     count;
        logic [CW-1:0]     count_next;
        logic              ready_q;
        logic              ovf_q;

        assign nonempty[i]   = (count != '0);
        assign push[i]       = adc_tvalid[i] & ready_q;
        assign head[i]       = mem[rd_ptr];
        assign adc_tready[i] = ready_q;
        assign ovf[i]        = ovf_q;

        // Occupancy after this cycle's push and pair pop
        always_comb begin
            count_next = count;
            case ({push[i], load})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end

        // Sample storage; contents are don't-care until written
        always_ff @(posedge clk) begin
            if (push[i]) begin
                mem[wr_ptr] <= din[i];
            end
        end

        // Pointers, occupancy, registered ready and sticky overflow
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                ready_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                if (push[i]) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (load) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count   <= count_next;
                ready_q <= (count_next != FULL_CNT);
                if (adc_tvalid[i] && (count == FULL_CNT)) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] mix;
    logic [DATA_W-1:0] proc_l;
    logic [DATA_W-1:0] proc_r;
    logic [DATA_W-1:0] sh_l;
    logic [DATA_W-1:0] sh_r;

    // Pair processing on the FIFO heads; mode/shift only matter on the load cycle
    always_comb begin
        sum    = {head[0][DATA_W-1], head[0]} + {head[1][DATA_W-1], head[1]};
        mix    = sum[DATA_W:1];
        proc_l = head[0];
        proc_r = head[1];
        case (mode)
            2'd1: begin
                proc_l = head[1];
                proc_r = head[0];
            end
            2'd2: begin
                proc_l = mix;
                proc_r = mix;
            end
            2'd3: begin
                proc_l = '0;
                proc_r = '0;
            end
            default: begin
                proc_l = head[0];
                proc_r = head[1];
            end
        endcase
        sh_l = DATA_W'($signed(proc_l) >>> shift);
        sh_r = DATA_W'($signed(proc_r) >>> shift);
    end

    // One-entry output registers per channel
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_tvalid  <= 2'b00;
            dac_l_tdata <= '0;
            dac_r_tdata <= '0;
        end else if (load) begin
            dac_tvalid  <= 2'b11;
            dac_l_tdata <= sh_l;
            dac_r_tdata <= sh_r;
        end else begin
            dac_tvalid  <= dac_tvalid & ~dac_tready;
        end
    end

    function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] x);
        if (!x[DATA_W-1]) begin
            return x;
        end
        if (x == MIN_NEG) begin
            return MAX_POS;
        end
        return (~x) + DATA_W'(1);
    endfunction

    logic          hit;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_next;

    // Joint level decision over both channels' accepted samples
    always_comb begin
        hit = (push[0] && (sat_abs(adc_l_tdata) >= THR))
            | (push[1] && (sat_abs(adc_r_tdata) >= THR));
        if (hit) begin
            hold_next = HOLD_LD;
        end else if (hold != '0) begin
            hold_next = hold - HW'(1);
        end else begin
            hold_next = '0;
        end
    end

    // Hold counter and LED, kept in step so the LED mirrors a nonzero count
    always_ff @(posedge clk) begin
        if (rst) begin
            hold    <= '0;
            led_out <= 1'b0;
        end else begin
            hold    <= hold_next;
            led_out <= (hold_next != '0);
        end
    end

endmodule

// File: tb/tb_i2s_stream_loop.sv
// Bench for i2s_stream_loop: directed scenarios then random traffic, all
// checked every cycle against a queue-based reference model.
module tb_i2s_stream_loop;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned HOLD  = 10;
    localparam longint      THR   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [2:0]    shift;
    logic [DW-1:0] adc_l_tdata, adc_r_tdata;
    logic [1:0]    adc_tvalid, adc_tready;
    logic [DW-1:0] dac_l_tdata, dac_r_tdata;
    logic [1:0]    dac_tvalid, dac_tready;
    logic [1:0]    ovf;
    logic          led_out;

    i2s_stream_loop #(
        .DATA_W(DW), .DEPTH(DEPTH), .THRESH(32'd16), .HOLD_CYC(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .shift(shift),
        .adc_l_tdata(adc_l_tdata), .adc_r_tdata(adc_r_tdata),
        .adc_tvalid(adc_tvalid), .adc_tready(adc_tready),
        .dac_l_tdata(dac_l_tdata), .dac_r_tdata(dac_r_tdata),
        .dac_tvalid(dac_tvalid), .dac_tready(dac_tready),
        .ovf(ovf), .led_out(led_out)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // Reference model state
    logic [DW-1:0] ql[$];
    logic [DW-1:0] qr[$];
    logic [DW-1:0] m_out [2];
    logic [1:0]    m_vld, m_ovf, m_rdy;
    int            m_hold;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sval(input logic [DW-1:0] x);
        return longint'($signed(x));
    endfunction

    function automatic bit loud(input logic [DW-1:0] x);
        longint a = sval(x);
        if (a < 0) a = -a;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        return a >= THR;
    endfunction

    task automatic model_step();
        logic [1:0] acc;
        bit         can, hit;
        longint     l, r, ol, orr;
        if (rst) begin
            ql.delete(); qr.delete();
            m_vld = 2'b00; m_out[0] = '0; m_out[1] = '0;
            m_ovf = 2'b00; m_hold = 0; m_rdy = 2'b00;
            return;
        end
        acc = adc_tvalid & m_rdy;
        if (adc_tvalid[0] && ql.size() == DEPTH) m_ovf[0] = 1'b1;
        if (adc_tvalid[1] && qr.size() == DEPTH) m_ovf[1] = 1'b1;
        can = ql.size() > 0 && qr.size() > 0
           && (!m_vld[0] || dac_tready[0]) && (!m_vld[1] || dac_tready[1]);
        m_vld = m_vld & ~dac_tready;
        if (can) begin
            l = sval(ql.pop_front());
            r = sval(qr.pop_front());
            case (mode)
                2'd0: begin ol = l; orr = r; end
                2'd1: begin ol = r; orr = l; end
                2'd2: begin ol = (l + r) >>> 1; orr = ol; end
                default: begin ol = 0; orr = 0; end
            endcase
            m_out[0] = 32'(ol >>> shift);
            m_out[1] = 32'(orr >>> shift);
            m_vld = 2'b11;
        end
        if (acc[0]) ql.push_back(adc_l_tdata);
        if (acc[1]) qr.push_back(adc_r_tdata);
        hit = (acc[0] && loud(adc_l_tdata)) || (acc[1] && loud(adc_r_tdata));
        if (hit) m_hold = HOLD;
        else if (m_hold > 0) m_hold--;
        m_rdy = {qr.size() < DEPTH, ql.size() < DEPTH};
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("adc_tready", 64'(adc_tready), 64'(m_rdy));
        chk("dac_tvalid", 64'(dac_tvalid), 64'(m_vld));
        chk("dac_l_tdata", 64'(dac_l_tdata), 64'(m_out[0]));
        chk("dac_r_tdata", 64'(dac_r_tdata), 64'(m_out[1]));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("led_out", 64'(led_out), 64'(m_hold != 0));
    endtask

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic [1:0] v);
        adc_l_tdata = l; adc_r_tdata = r; adc_tvalid = v;
        tick();
        adc_tvalid = 2'b00;
    endtask

    initial begin
        int cnt;
        int v;
        rst = 1'b1; mode = 2'd0; shift = 3'd0;
        adc_l_tdata = '0; adc_r_tdata = '0; adc_tvalid = 2'b00; dac_tready = 2'b11;

        // Reset state
        tick(); tick();
        chk("rst_tready", 64'(adc_tready), 64'(2'b00));
        rst = 1'b0;
        tick();
        chk("post_rst_tready", 64'(adc_tready), 64'(2'b11));

        // Pass: L=5 R=-3, valid one cycle after the accept edge
        push(32'd5, 32'hFFFF_FFFD, 2'b11);
        chk("pass_not_yet", 64'(dac_tvalid), 64'(2'b00));
        tick();
        chk("pass_valid", 64'(dac_tvalid), 64'(2'b11));
        chk("pass_l", 64'(dac_l_tdata), 64'(32'd5));
        chk("pass_r", 64'(dac_r_tdata), 64'(32'hFFFF_FFFD));
        tick();
        chk("pass_one_cycle", 64'(dac_tvalid), 64'(2'b00));

        // Mix with shift, then swap
        mode = 2'd2; shift = 3'd1;
        push(32'd100, 32'hFFFF_FFD8, 2'b11);
        tick();
        chk("mix_l", 64'(dac_l_tdata), 64'(32'd15));
        chk("mix_r", 64'(dac_r_tdata), 64'(32'd15));
        mode = 2'd1; shift = 3'd0;
        push(32'd100, 32'hFFFF_FFD8, 2'b11);
        tick();
        chk("swap_l", 64'(dac_l_tdata), 64'(32'hFFFF_FFD8));
        chk("swap_r", 64'(dac_r_tdata), 64'(32'd100));
        tick(); tick();

        // Backpressure: overfill, then drain in order
        mode = 2'd0; dac_tready = 2'b00;
        for (int i = 0; i < 2 * DEPTH + 2; i++) push($urandom, $urandom, 2'b11);
        chk("bp_tready", 64'(adc_tready), 64'(2'b00));
        chk("bp_ovf", 64'(ovf), 64'(2'b11));
        dac_tready = 2'b11;
        cnt = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (dac_tvalid[0]) cnt++;
            tick();
        end
        chk("bp_drained_pairs", 64'(cnt), 64'(DEPTH + 1));

        // Skew: L only, then R one at a time
        for (int i = 0; i < DEPTH; i++) push($urandom, '0, 2'b01);
        chk("skew_no_out", 64'(dac_tvalid), 64'(2'b00));
        for (int i = 0; i < DEPTH; i++) begin
            push('0, $urandom, 2'b10);
            tick(); tick();
        end

        // Level: most negative value holds LED for HOLD cycles; 15 has no effect
        cnt = 0;
        push(32'h8000_0000, 32'd0, 2'b11);
        if (led_out) cnt++;
        for (int i = 0; i < HOLD + 3; i++) begin
            tick();
            if (led_out) cnt++;
        end
        chk("led_hold_len", 64'(cnt), 64'(HOLD));
        push(32'd15, 32'd15, 2'b11);
        tick(); tick();
        chk("led_quiet", 64'(led_out), 64'(1'b0));
        push(32'd20, 32'hFFFF_FFEC, 2'b11);
        tick(); tick();

        // Reset mid-transfer: one pair on the output, three queued
        dac_tready = 2'b00;
        for (int i = 0; i < 4; i++) push($urandom, $urandom, 2'b11);
        chk("rst_pre_valid", 64'(dac_tvalid), 64'(2'b11));
        rst = 1'b1;
        tick();
        chk("rst_valid_clr", 64'(dac_tvalid), 64'(2'b00));
        chk("rst_ovf_clr", 64'(ovf), 64'(2'b00));
        rst = 1'b0; dac_tready = 2'b11;
        tick();
        push(32'h1234_5678, 32'h0BAD_F00D, 2'b11);
        tick();
        chk("rst_new_l", 64'(dac_l_tdata), 64'(32'h1234_5678));
        chk("rst_new_r", 64'(dac_r_tdata), 64'(32'h0BAD_F00D));
        tick();
        chk("rst_no_stale", 64'(dac_tvalid), 64'(2'b00));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            mode = 2'($urandom);
            shift = 3'($urandom);
            adc_tvalid = 2'($urandom);
            dac_tready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            if ($urandom_range(0, 3) == 0) adc_l_tdata = $urandom;
            else begin v = int'($urandom_range(0, 40)) - 20; adc_l_tdata = 32'(v); end
            if ($urandom_range(0, 3) == 0) adc_r_tdata = $urandom;
            else begin v = int'($urandom_range(0, 40)) - 20; adc_r_tdata = 32'(v); end
            tick();
        end
        rst = 1'b0; adc_tvalid = 2'b00; dac_tready = 2'b11;
        for (int i = 0; i < DEPTH + 4; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/i2s_stream_loop.md
I2S_STREAM_LOOP -- requirements
Module: i2s_stream_loop

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the sample width in bits (two's complement).
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the per-channel FIFO depth in samples (power of 2, >= 2).
REQ-003 The block SHALL have parameter THRESH, default 32'h1000_0000, giving the level-detect threshold on |sample|.
REQ-004 The block SHALL have parameter HOLD_CYC, default 2_500_000, giving the led_out hold time in clk cycles.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: the clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port mode, input, 2 bits: 0 pass, 1 swap L/R, 2 mono mix, 3 mute.
REQ-008 The block SHALL have port shift, input, 3 bits: arithmetic right-shift attenuation, 0..7.
REQ-009 The block SHALL have ports adc_l_tdata and adc_r_tdata, input, DATA_W bits each: input samples.
REQ-010 The block SHALL have port adc_tvalid, input, 2 bits, bit0 = L and bit1 = R: input sample valid.
REQ-011 The block SHALL have port adc_tready, output, 2 bits: input ready per channel.
REQ-012 The block SHALL have ports dac_l_tdata and dac_r_tdata, output, DATA_W bits each: output samples.
REQ-013 The block SHALL have port dac_tvalid, output, 2 bits: output sample valid per channel.
REQ-014 The block SHALL have port dac_tready, input, 2 bits: output ready per channel.
REQ-015 The block SHALL have port ovf, output, 2 bits: sticky per-channel input overflow flag.
REQ-016 The block SHALL have port led_out, output, 1 bit: level indicator.

Function
REQ-017 Each channel SHALL have an independent DEPTH-entry FIFO, with a write on adc_tvalid[i] & adc_tready[i].
REQ-018 adc_tready[i] SHALL be high exactly when FIFO i is not full, including when a pop happens in the same cycle.
REQ-019 Simultaneous push and pop on a non-full FIFO SHALL both take effect with the occupancy unchanged, and read/write pointers SHALL wrap modulo DEPTH.
REQ-020 Each channel SHALL have a one-entry output register; dac_tvalid[i] SHALL be its valid bit, and the entry SHALL be consumed on dac_tvalid[i] & dac_tready[i].
REQ-021 A pair load SHALL pop both FIFOs together, and SHALL occur only when both FIFOs are non-empty and each output register is empty or being consumed in that cycle.
REQ-022 mode and shift SHALL be sampled at the pair load, so a change never splits an L/R pair.
REQ-023 Processing for pair (L,R) SHALL be: mode 0 gives (L,R); mode 1 gives (R,L); mode 2 gives (M,M) with M=(L+R)>>>1 computed at DATA_W+1 bits and no overflow; mode 3 gives (0,0), with the pair still consumed.
REQ-024 The result SHALL then be shifted arithmetically right by shift, so that -8 >>> 2 = -2.
REQ-025 Latency SHALL be: with both FIFOs empty, both outputs empty, and samples accepted at edge k, dac_tvalid SHALL be high after edge k+1.
REQ-026 ovf[i] SHALL be set on any cycle with adc_tvalid[i]=1 and FIFO i full, and SHALL stay set until rst; the rejected sample SHALL not be stored.
REQ-027 Level detect SHALL compute |x| for every accepted input sample, saturating the most negative value to the maximum positive value.
REQ-028 If |x| >= THRESH on either channel, the hold counter SHALL load HOLD_CYC; otherwise it SHALL decrement to 0 and stop there.
REQ-029 led_out SHALL be registered and SHALL be high exactly while the hold counter is nonzero.
REQ-030 When L and R are accepted in the same cycle, they SHALL be evaluated jointly, and a single counter load SHALL result.

Reset
REQ-031 rst SHALL empty both FIFOs and clear both output registers, so dac_tvalid=0 and dac_*_tdata=0.
REQ-032 rst SHALL clear ovf to 0, the hold counter to 0, and led_out to 0.
REQ-033 During rst, adc_tready SHALL be 0; it SHALL be 2'b11 on the cycle after rst deasserts.
REQ-034 rst asserted mid-transfer SHALL discard all buffered samples, with no partial pair emitted afterward.

Verification
REQ-035 Pass test: mode=0, shift=0, input L=5, R=-3 in one cycle, dac_tready=11 -> dac L=5, R=-3, tvalid high after edge k+1, one cycle only.
REQ-036 Mix/shift test: mode=2, shift=1, input L=100, R=-40 -> both outputs 15; mode=1 -> outputs L=-40, R=100 (shift=0).
REQ-037 Backpressure test: dac_tready=00 with 2*DEPTH+2 L/R pairs pushed -> DEPTH+1 pairs held, adc_tready=00, ovf=11; release -> outputs in order with no loss of the held pairs.
REQ-038 Skew test: DEPTH L samples pushed with no R -> dac_tvalid stays 00; each later R sample yields one pair in order.
REQ-039 Level test: THRESH=16 and HOLD_CYC=10, one sample of -2^(DATA_W-1) -> led_out high for exactly 10 cycles, then low; a sample of 15 -> no effect.
REQ-040 Reset test: rst with 3 pairs queued and one pair on the output -> next cycle dac_tvalid=0 and ovf=0, and subsequent output shows only post-reset data.
